// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the multicycle execution unit
package mc_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_ORR = 3'b011;
  localparam logic [2:0] OP_LSL = 3'b100;
  localparam logic [2:0] OP_LSR = 3'b101;
  localparam logic [2:0] OP_ASR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == OP_LSL) || (op == OP_LSR) || (op == OP_ASR);
  endfunction

endpackage

// File: rtl/mc_alu_flags.sv
// rtl/mc_alu_flags.sv - combinational add/sub/logic result with NZCV generation
module mc_alu_flags #(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);
  import mc_pkg::*;

  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             c;
  logic             v;

  always_comb begin
    sub   = (op == OP_SUB);
    b_eff = sub ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    c     = 1'b0;
    v     = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        result = sum[WIDTH-1:0];
        c      = sum[WIDTH];
        v      = (a[WIDTH-1] == b_eff[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  result = a & b;
      OP_ORR:  result = a | b;
      // Shift/MUL results arrive precomputed on a; only N/Z and the supplied carry apply.
      default: begin
        result = a;
        c      = c_in;
      end
    endcase
    flags         = 4'b0000;
    flags[FLAG_N] = result[WIDTH-1];
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_C] = c;
    flags[FLAG_V] = v;
  end

endmodule

// File: rtl/mc_exec_unit.sv
// rtl/mc_exec_unit.sv - multicycle execution unit with iterative shifts and shift-add multiply
module mc_exec_unit #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);
  import mc_pkg::*;

  localparam int AW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             done_q, done_d;

  logic             idle, shift_op, multi;
  logic [AW-1:0]    amt;
  logic [2:0]       src_op;
  logic [WIDTH-1:0] src_w, src_mcand, src_mplier;
  logic [WIDTH-1:0] step_w, step_mcand, step_mplier;
  logic             step_c;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_a, alu_b, alu_res;
  logic             alu_c;
  logic [3:0]       alu_flags;

  // The first step runs on the accepting edge from the raw inputs, so L edges give L steps.
  always_comb begin
    idle        = (state_q == ST_IDLE);
    amt         = b[AW-1:0];
    shift_op    = is_shift_op(op);
    multi       = (shift_op && (amt > AW'(1))) || ((op == OP_MUL) && MUL_EN);
    src_op      = idle ? op : op_q;
    src_w       = idle ? ((op == OP_MUL) ? '0 : a) : work_q;
    src_mcand   = idle ? a : mcand_q;
    src_mplier  = idle ? b : mplier_q;
    step_c      = 1'b0;
    case (src_op)
      OP_LSL: begin
        step_w = {src_w[WIDTH-2:0], 1'b0};
        step_c = src_w[WIDTH-1];
      end
      OP_LSR: begin
        step_w = {1'b0, src_w[WIDTH-1:1]};
        step_c = src_w[0];
      end
      OP_ASR: begin
        step_w = {src_w[WIDTH-1], src_w[WIDTH-1:1]};
        step_c = src_w[0];
      end
      default: step_w = src_w + (src_mplier[0] ? src_mcand : '0);
    endcase
    step_mcand  = src_mcand << 1;
    step_mplier = src_mplier >> 1;
  end

  always_comb begin
    alu_op = src_op;
    alu_b  = b;
    alu_a  = step_w;
    alu_c  = step_c;
    if (idle) begin
      alu_a = a;
      alu_c = 1'b0;
      if (shift_op && (amt == AW'(1))) begin
        alu_a = step_w;
        alu_c = step_c;
      end
      if (op == OP_MUL) alu_a = '0;
    end
  end

  mc_alu_flags #(.WIDTH(WIDTH)) u_alu (
    .op     (alu_op),
    .a      (alu_a),
    .b      (alu_b),
    .c_in   (alu_c),
    .result (alu_res),
    .flags  (alu_flags)
  );

  always_comb begin
    op_d     = op_q;
    work_d   = work_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    if (idle) begin
      if (start) begin
        op_d = op;
        if (multi) begin
          work_d   = step_w;
          mcand_d  = step_mcand;
          mplier_d = step_mplier;
          cnt_d    = (op == OP_MUL) ? AW'(WIDTH - 2) : amt - AW'(2);
        end else begin
          result_d = alu_res;
          flags_d  = alu_flags;
          done_d   = 1'b1;
        end
      end
    end else begin
      work_d   = step_w;
      mcand_d  = step_mcand;
      mplier_d = step_mplier;
      if (cnt_q == '0) begin
        result_d = alu_res;
        flags_d  = alu_flags;
        done_d   = 1'b1;
      end else begin
        cnt_d = cnt_q - AW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= 3'b000;
      work_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      flags_q  <= 4'b0000;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      work_q   <= work_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start && multi) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == '0) state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q == ST_RUN);
    done   = done_q;
    result = result_q;
    flags  = flags_q;
  end

endmodule
